keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and delivers one 4-bit key code per press over a valid/ready handshake. It sits directly downstream of the frequency divider. It consumes the divider's slow_clk, about 500 Hz and 2 ms period, as a sampled scan-rate input, never as a clock. All logic runs on the 27 MHz clk.

## Interface
- DEBOUNCE_TICKS, default 4: consecutive identical scan ticks required to accept a press or a release; legal range 2..15.
- clk  in  1  system clock, 27 MHz.
- rst  in  1  synchronous, active-low reset.
- scan_clk  in  1  slow clock from the divider; treated as asynchronous data.
- col_i  in  4  keypad columns, active-low with external pull-ups; asynchronous.
- row_o  out  4  keypad row drive, active-low, one-hot-zero.
- key_code  out  4  raw code, row*4 + col.
- key_valid  out  1  key_code holds a pending key.
- key_ready  in  1  consumer accepts the key.
- key_lost  out  1  one-cycle pulse when an accepted press is dropped.

## Operation
- scan_clk passes through a 2-flop synchronizer and a rising-edge detector, producing `tick`, a one-clk pulse.
- col_i passes through a 2-flop synchronizer, producing col_s. All decisions sample col_s only on tick.
- row_o = ~(4'b0001 << row_idx). Row drive changes only on tick, so columns have one full tick period to settle.
- FSM states SCAN, DEBOUNCE, HELD; all transitions happen only on tick. Transitions:
  - SCAN, col_s == 4'hF: row_idx++ (wraps 3 -> 0).
  - SCAN, col_s != 4'hF: col_cap <= col_s; cnt <= 1; go to DEBOUNCE; row held.
  - DEBOUNCE, col_s == col_cap: cnt++. When cnt reaches DEBOUNCE_TICKS, the press is accepted and the FSM goes to HELD.
  - DEBOUNCE, col_s != col_cap (including 4'hF): row_idx++, go to SCAN, no output.
  - HELD, col_s == 4'hF: rel_cnt++. At DEBOUNCE_TICKS, row_idx++ and go to SCAN.
  - HELD, col_s != 4'hF: rel_cnt <= 0.
- Column encoding: the lowest-index zero bit of col_cap wins when several columns are low.
- Output behaviour on an accepted press:
  - key_valid = 0: load key_code, set key_valid.
  - key_valid = 1 and key_ready = 1 in the same cycle: load the new code and keep key_valid high; no loss.
  - key_valid = 1 and key_ready = 0: keep the old code, pulse key_lost.
- Handshake: key_code is stable while key_valid is high. A cycle with key_valid & key_ready high clears key_valid on the next edge, unless a new key loads in that same cycle.
- Only one key per press is reported; there is no auto-repeat.

## Timing
- Reset values: row_o = 4'b1110, key_code = 4'h0, key_valid = 0, key_lost = 0. Internal reset values:
  - state SCAN, row_idx = 0, cnt = 0, rel_cnt = 0.
  - col synchronizer = 4'hF, scan_clk synchronizer and edge register = 0.
- Reset asserted mid-operation takes effect on the next clk edge from any state. A pending key is discarded.
- tick pulses 3 clk cycles after a scan_clk rising edge: 2 synchronizer cycles plus 1 edge-register cycle.
- key_valid rises 1 clk after the accepting tick.
- Press-to-valid latency is DEBOUNCE_TICKS ticks from the first tick that sees the press on the driven row, plus 1 clk.
- With the divider at 2 ms per tick and the default parameter, one press takes 8 ms and a full idle row sweep takes 8 ms.
- key_lost is high for exactly 1 clk.
- cnt and rel_cnt are 4 bits wide and saturate; they never wrap.

## Structure
- Shared package keypad_pkg holds:
  - typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;
  - NUM_ROWS = 4, NUM_COLS = 4;
  - function kp_legend(code), mapping raw code to the keypad legend for display blocks.
- Sub-module sync_edge: a 2-flop synchronizer plus rising-edge pulse, instantiated once for scan_clk. A plain 2-flop synchronizer for col_i stays in the keypad_scanner top.

## Test plan
- Reset, no key pressed, bench toggling scan_clk: row_o cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per tick; key_valid stays 0.
- Key at row 2, col 1 held for 6 ticks with DEBOUNCE_TICKS = 4 -> key_code = 4'h9 and key_valid = 1 exactly 1 clk after the 4th tick. key_ready held low keeps key_code stable; a key_ready pulse clears key_valid the next cycle.
- Bouncing press where col_i is low for 2 ticks, high for 1, then low: no key_valid. The FSM returns to SCAN and the press is accepted only after 4 stable ticks on a later visit to that row.
- Release bounce: during HELD, col_i toggles before 4 consecutive idle ticks -> no second key; after a clean release, the next press of the same key yields a second key_valid.
- Two presses (row 0/col 0, then row 3/col 3) with key_ready = 0 -> key_code stays 4'h0 and key_lost pulses 1 clk. A repeat with key_ready = 1 in the accept cycle -> key_code = 4'hF and no key_lost.
- rst low during DEBOUNCE with key_valid = 1 -> next clk: row_o = 1110, key_valid = 0, key_code = 0, and scanning restarts at row 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and helpers for the 4x4 matrix keypad scanner.
//   kp_state_t   : scanner FSM state encoding
//   NUM_ROWS/COLS: keypad matrix geometry
//   kp_first_low : index of the lowest-numbered low column in an active-low column word
//   kp_legend    : raw key code (row*4 + col) to the ASCII legend printed on the keypad
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} kp_state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Lowest-index zero wins when several columns are pulled low together.
  function automatic logic [1:0] kp_first_low(input logic [NUM_COLS-1:0] cols);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (!cols[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Standard 4x4 membrane layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [7:0] kp_legend(input logic [3:0] code);
    logic [7:0] ch;
    case (code)
      4'h0: ch = "1";
      4'h1: ch = "2";
      4'h2: ch = "3";
      4'h3: ch = "A";
      4'h4: ch = "4";
      4'h5: ch = "5";
      4'h6: ch = "6";
      4'h7: ch = "B";
      4'h8: ch = "7";
      4'h9: ch = "8";
      4'hA: ch = "9";
      4'hB: ch = "C";
      4'hC: ch = "*";
      4'hD: ch = "0";
      4'hE: ch = "#";
      default: ch = "D";
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_edge.sv
// sync_edge
// Two-flop synchronizer followed by a rising-edge detector. The output pulse is
// registered, so it appears 3 clk cycles after the asynchronous input rises and
// lasts exactly one clk.
//   clk   : system clock
//   rst   : synchronous, active-low reset (all flops clear to 0)
//   din   : asynchronous level input
//   pulse : one-clk pulse per rising edge of din
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      meta  <= din;
      sync  <= meta;
      prev  <= sync;
      pulse <= sync & ~prev;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one row per scan tick, debounces press
// and release, and hands one key code per press to a valid/ready consumer.
// scan_clk (about 500 Hz from the divider) is sampled as data, never used as a clock.
//   clk       : 27 MHz system clock
//   rst       : synchronous, active-low reset
//   scan_clk  : slow scan-rate input, asynchronous
//   col_i     : keypad columns, active-low, asynchronous
//   row_o     : row drive, active-low, one row low at a time
//   key_code  : row*4 + col of the pending key
//   key_valid : key_code holds a pending key
//   key_ready : consumer accepts the pending key
//   key_lost  : one-clk pulse when an accepted press could not be delivered
//
// state    | meaning
// ---------+---------------------------------------------------------------
// SCAN     | no key seen on the driven row; advance row each tick
// DEBOUNCE | a column went low; count identical ticks before accepting
// HELD     | press accepted; wait for DEBOUNCE_TICKS idle ticks to release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_clk,
  input  logic [NUM_COLS-1:0] col_i,
  output logic [NUM_ROWS-1:0] row_o,
  output logic [3:0]          key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_lost
);

  localparam logic [3:0]          DB_TC    = 4'(DEBOUNCE_TICKS);
  localparam logic [NUM_COLS-1:0] COL_IDLE = '1;

  logic                tick;
  logic [NUM_COLS-1:0] col_m;
  logic [NUM_COLS-1:0] col_s;

  kp_state_t           state, state_n;
  logic [1:0]          row_idx, row_idx_n;
  logic [3:0]          cnt, cnt_n;
  logic [3:0]          rel_cnt, rel_cnt_n;
  logic [NUM_COLS-1:0] col_cap, col_cap_n;
  logic [3:0]          cnt_inc;
  logic [3:0]          rel_inc;
  logic                accept;
  logic [3:0]          code_new;

  sync_edge u_scan_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (scan_clk),
    .pulse (tick)
  );

  // Columns idle high through reset so the first samples never look like a press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_m <= COL_IDLE;
      col_s <= COL_IDLE;
    end else begin
      col_m <= col_i;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SCAN;
      row_idx <= 2'd0;
      cnt     <= 4'd0;
      rel_cnt <= 4'd0;
      col_cap <= COL_IDLE;
    end else begin
      state   <= state_n;
      row_idx <= row_idx_n;
      cnt     <= cnt_n;
      rel_cnt <= rel_cnt_n;
      col_cap <= col_cap_n;
    end
  end

  // Saturating increments: the counters must never wrap back below the threshold.
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign rel_inc = (rel_cnt == 4'hF) ? rel_cnt : rel_cnt + 4'd1;

  always_comb begin
    state_n   = state;
    row_idx_n = row_idx;
    cnt_n     = cnt;
    rel_cnt_n = rel_cnt;
    col_cap_n = col_cap;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (col_s == COL_IDLE) begin
            row_idx_n = row_idx + 2'd1;
          end else begin
            // The row stays driven so the debounce keeps watching the same key.
            col_cap_n = col_s;
            cnt_n     = 4'd1;
            state_n   = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (col_s == col_cap) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= DB_TC) begin
              accept    = 1'b1;
              rel_cnt_n = 4'd0;
              state_n   = HELD;
            end
          end else begin
            // Bounce or a different column: give up and move on; the key is
            // picked up again on a later visit to this row.
            cnt_n     = 4'd0;
            row_idx_n = row_idx + 2'd1;
            state_n   = SCAN;
          end
        end
        HELD: begin
          if (col_s == COL_IDLE) begin
            rel_cnt_n = rel_inc;
            if (rel_inc >= DB_TC) begin
              rel_cnt_n = 4'd0;
              cnt_n     = 4'd0;
              row_idx_n = row_idx + 2'd1;
              state_n   = SCAN;
            end
          end else begin
            rel_cnt_n = 4'd0;
          end
        end
        default: begin
          state_n = SCAN;
        end
      endcase
    end
  end

  assign code_new = {row_idx, kp_first_low(col_cap)};

  // A new key can replace the pending one only when the consumer takes the old
  // one in the same cycle; otherwise the old code is kept and the new press is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_lost  <= 1'b0;
    end else begin
      key_lost <= 1'b0;
      if (accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= code_new;
          key_valid <= 1'b1;
        end else begin
          key_lost <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign row_o = ~(4'b0001 << row_idx);

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic       scan_clk;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_lost;

  // Keypad model: a pressed key pulls its column low only while its row is driven low.
  logic       pressed;
  logic [1:0] prow;
  logic [1:0] pcol;

  int vectors = 0;
  int errors  = 0;

  logic kv_n3, kv_n4, lost_n4, lost_n5;

  keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_clk  (scan_clk),
    .col_i     (col_i),
    .row_o     (row_o),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_lost  (key_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    col_i = 4'hF;
    if (pressed && !row_o[prow]) col_i = ~(4'b0001 << pcol);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scan tick, entered and left on a falling clk edge. scan_clk rises at N0;
  // tick is high in the cycle ending at the 4th rising edge, where the FSM acts.
  // rdy drives key_ready only during that acting cycle.
  task automatic do_tick(input logic rdy);
    scan_clk = 1'b1;
    repeat (3) @(negedge clk);
    kv_n3     = key_valid;
    key_ready = rdy;
    @(negedge clk);
    kv_n4     = key_valid;
    lost_n4   = key_lost;
    key_ready = 1'b0;
    @(negedge clk);
    lost_n5   = key_lost;
    scan_clk  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    prow    = r;
    pcol    = c;
    pressed = 1'b1;
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; scan_clk = 1'b0; key_ready = 1'b0;
    pressed = 1'b0; prow = 2'd0; pcol = 2'd0;
    repeat (4) @(negedge clk);
    check("reset_row", 8'(row_o), 8'h0E);
    check("reset_valid", 8'(key_valid), 8'h0);
    check("reset_code", 8'(key_code), 8'h0);
    check("reset_lost", 8'(key_lost), 8'h0);
    rst = 1'b1;
    @(negedge clk);

    // idle sweep
    do_tick(1'b0); check("sweep_r1", 8'(row_o), 8'h0D);
    do_tick(1'b0); check("sweep_r2", 8'(row_o), 8'h0B);
    do_tick(1'b0); check("sweep_r3", 8'(row_o), 8'h07);
    do_tick(1'b0); check("sweep_r0", 8'(row_o), 8'h0E);
    check("sweep_valid", 8'(key_valid), 8'h0);

    // row 2 col 1 -> code 9
    press(2'd2, 2'd1);
    ticks(2); check("k9_row", 8'(row_o), 8'h0B);
    ticks(3); check("k9_pre_valid", 8'(key_valid), 8'h0);
    check("k9_row_hold", 8'(row_o), 8'h0B);
    do_tick(1'b0);
    check("k9_valid_n3", 8'(kv_n3), 8'h0);
    check("k9_valid_n4", 8'(kv_n4), 8'h1);
    check("k9_code", 8'(key_code), 8'h9);
    ticks(2);
    check("k9_stable_code", 8'(key_code), 8'h9);
    check("k9_stable_valid", 8'(key_valid), 8'h1);
    pulse_ready();
    check("k9_ready_clear", 8'(key_valid), 8'h0);
    pressed = 1'b0;
    ticks(3); check("k9_rel_hold", 8'(row_o), 8'h0B);
    do_tick(1'b0); check("k9_rel_done", 8'(row_o), 8'h07);

    // bouncing press at row 0 col 2
    ticks(1); check("bnc_row0", 8'(row_o), 8'h0E);
    press(2'd0, 2'd2);
    ticks(2);
    pressed = 1'b0;
    ticks(1);
    check("bnc_abort_row", 8'(row_o), 8'h0D);
    check("bnc_abort_valid", 8'(key_valid), 8'h0);
    pressed = 1'b1;
    ticks(3); check("bnc_revisit", 8'(row_o), 8'h0E);
    ticks(3); check("bnc_pre_valid", 8'(key_valid), 8'h0);
    do_tick(1'b0);
    check("bnc_valid", 8'(key_valid), 8'h1);
    check("bnc_code", 8'(key_code), 8'h2);
    pulse_ready();
    pressed = 1'b0;
    ticks(4); check("bnc_rel_row", 8'(row_o), 8'h0D);

    // release bounce at row 1 col 3 -> code 7
    press(2'd1, 2'd3);
    ticks(3); do_tick(1'b0);
    check("rb_valid", 8'(key_valid), 8'h1);
    check("rb_code", 8'(key_code), 8'h7);
    pulse_ready();
    pressed = 1'b0; ticks(2);
    pressed = 1'b1; ticks(1);
    pressed = 1'b0; ticks(3);
    check("rb_still_held", 8'(row_o), 8'h0D);
    check("rb_no_second", 8'(key_valid), 8'h0);
    pressed = 1'b1; ticks(1);
    pressed = 1'b0; ticks(4);
    check("rb_released", 8'(row_o), 8'h0B);
    check("rb_released_valid", 8'(key_valid), 8'h0);
    pressed = 1'b1;
    ticks(3); check("rb_again_row", 8'(row_o), 8'h0D);
    ticks(3); do_tick(1'b0);
    check("rb_again_valid", 8'(key_valid), 8'h1);
    check("rb_again_code", 8'(key_code), 8'h7);
    pulse_ready();
    pressed = 1'b0; ticks(4);

    // two presses with key_ready low
    press(2'd0, 2'd0);
    ticks(2); ticks(3); do_tick(1'b0);
    check("lost_first_valid", 8'(key_valid), 8'h1);
    check("lost_first_code", 8'(key_code), 8'h0);
    pressed = 1'b0; ticks(4);
    check("lost_rel_row", 8'(row_o), 8'h0D);
    press(2'd3, 2'd3);
    ticks(2); ticks(3); do_tick(1'b0);
    check("lost_pulse", 8'(lost_n4), 8'h1);
    check("lost_pulse_end", 8'(lost_n5), 8'h0);
    check("lost_code_kept", 8'(key_code), 8'h0);
    check("lost_valid_kept", 8'(key_valid), 8'h1);
    pressed = 1'b0; ticks(4);
    check("lost_rel2_row", 8'(row_o), 8'h0E);
    pressed = 1'b1;
    ticks(3); ticks(3); do_tick(1'b1);
    check("swap_code", 8'(key_code), 8'hF);
    check("swap_valid", 8'(key_valid), 8'h1);
    check("swap_no_lost", 8'(lost_n4), 8'h0);

    // reset during DEBOUNCE with a pending key
    pressed = 1'b0; ticks(4);
    press(2'd0, 2'd1);
    ticks(2);
    check("rst_pre_valid", 8'(key_valid), 8'h1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_row", 8'(row_o), 8'h0E);
    check("rst_valid", 8'(key_valid), 8'h0);
    check("rst_code", 8'(key_code), 8'h0);
    check("rst_lost", 8'(key_lost), 8'h0);
    rst = 1'b1;
    @(negedge clk);
    ticks(3);
    check("rst_restart_pre", 8'(key_valid), 8'h0);
    check("rst_restart_row", 8'(row_o), 8'h0E);
    do_tick(1'b0);
    check("rst_restart_n3", 8'(kv_n3), 8'h0);
    check("rst_restart_valid", 8'(key_valid), 8'h1);
    check("rst_restart_code", 8'(key_code), 8'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
